// File: rtl/iobuff_sequencer.sv
// iobuff_sequencer: applies per-channel iobuff configuration commands with a
// break-before-make sequence (output enable dropped, settle, apply od/dir/dout,
// settle, then restore output enable) so a pad is never driven while its
// direction or open-drain mode is changing. Also synchronizes raw pin input.
module iobuff_sequencer #(
    parameter int unsigned NPINS  = 4,
    parameter int unsigned SETTLE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_pin,
    input  logic             cmd_oe,
    input  logic             cmd_od,
    input  logic             cmd_dir,
    input  logic             cmd_dout,
    output logic [NPINS-1:0] buf_oe,
    output logic [NPINS-1:0] buf_od,
    output logic [NPINS-1:0] buf_dir,
    output logic [NPINS-1:0] buf_dout,
    input  logic [NPINS-1:0] pin_din,
    output logic [NPINS-1:0] din_sync,
    output logic             done,
    output logic             cmd_err,
    output logic             busy
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OE_OFF = 2'd1,
        APPLY  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         pin_q, pin_d;
    logic               oe_q, oe_d;
    logic               od_q, od_d;
    logic               dir_q, dir_d;
    logic               dout_q, dout_d;
    logic [NPINS-1:0]   buf_oe_q, buf_oe_d;
    logic [NPINS-1:0]   buf_od_q, buf_od_d;
    logic [NPINS-1:0]   buf_dir_q, buf_dir_d;
    logic [NPINS-1:0]   buf_dout_q, buf_dout_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic [NPINS-1:0]   sync1_q, sync1_d;
    logic [NPINS-1:0]   sync2_q, sync2_d;

    logic [NPINS-1:0]   cmd_hit_c;
    logic [NPINS-1:0]   lat_hit_c;
    logic               cmd_pin_ok_c;
    logic               cur_oe_c;
    logic               fast_c;

    // Replace the masked channel bit(s) of v with b, leaving all others intact.
    function automatic logic [NPINS-1:0] put_bit(input logic [NPINS-1:0] v,
                                                 input logic [NPINS-1:0] m,
                                                 input logic             b);
        put_bit = (v & ~m) | (b ? m : '0);
    endfunction

    // One-hot channel masks for the incoming and the latched pin index.
    always_comb begin
        cmd_hit_c = '0;
        lat_hit_c = '0;
        for (int unsigned i = 0; i < NPINS; i++) begin
            if (cmd_pin == 2'(i)) cmd_hit_c[i] = 1'b1;
            if (pin_q == 2'(i))   lat_hit_c[i] = 1'b1;
        end
    end

    // Classify the incoming command against the channel's current settings.
    always_comb begin
        cmd_pin_ok_c = |cmd_hit_c;
        cur_oe_c     = |(buf_oe_q & cmd_hit_c);
        fast_c       = (cur_oe_c == cmd_oe)
                    && ((|(buf_od_q & cmd_hit_c)) == cmd_od)
                    && ((|(buf_dir_q & cmd_hit_c)) == cmd_dir);
    end

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pin_d      = pin_q;
        oe_d       = oe_q;
        od_d       = od_q;
        dir_d      = dir_q;
        dout_d     = dout_q;
        buf_oe_d   = buf_oe_q;
        buf_od_d   = buf_od_q;
        buf_dir_d  = buf_dir_q;
        buf_dout_d = buf_dout_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cmd_valid && ready_q) begin
                    pin_d  = cmd_pin;
                    oe_d   = cmd_oe;
                    od_d   = cmd_od;
                    dir_d  = cmd_dir;
                    dout_d = cmd_dout;
                    if (!cmd_pin_ok_c) begin
                        // Out-of-range channel: reject without touching any pad.
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (fast_c) begin
                        // Only data may differ; no pad mode change, so no settle.
                        state_d    = DONE;
                        done_d     = 1'b1;
                        buf_dout_d = put_bit(buf_dout_q, cmd_hit_c, cmd_dout);
                    end else if (cur_oe_c) begin
                        state_d  = OE_OFF;
                        cnt_d    = SETTLE_LOAD;
                        buf_oe_d = put_bit(buf_oe_q, cmd_hit_c, 1'b0);
                    end else begin
                        state_d    = APPLY;
                        cnt_d      = SETTLE_LOAD;
                        buf_od_d   = put_bit(buf_od_q, cmd_hit_c, cmd_od);
                        buf_dir_d  = put_bit(buf_dir_q, cmd_hit_c, cmd_dir);
                        buf_dout_d = put_bit(buf_dout_q, cmd_hit_c, cmd_dout);
                    end
                end
            end
            OE_OFF: begin
                if (cnt_q == '0) begin
                    state_d    = APPLY;
                    cnt_d      = SETTLE_LOAD;
                    buf_od_d   = put_bit(buf_od_q, lat_hit_c, od_q);
                    buf_dir_d  = put_bit(buf_dir_q, lat_hit_c, dir_q);
                    buf_dout_d = put_bit(buf_dout_q, lat_hit_c, dout_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            APPLY: begin
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    buf_oe_d = put_bit(buf_oe_q, lat_hit_c, oe_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        sync1_d = pin_din;
        sync2_d = sync1_q;
    end

    // State, command latch, pad controls and synchronizer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pin_q      <= '0;
            oe_q       <= 1'b0;
            od_q       <= 1'b0;
            dir_q      <= 1'b0;
            dout_q     <= 1'b0;
            buf_oe_q   <= '0;
            buf_od_q   <= '0;
            buf_dir_q  <= '0;
            buf_dout_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pin_q      <= pin_d;
            oe_q       <= oe_d;
            od_q       <= od_d;
            dir_q      <= dir_d;
            dout_q     <= dout_d;
            buf_oe_q   <= buf_oe_d;
            buf_od_q   <= buf_od_d;
            buf_dir_q  <= buf_dir_d;
            buf_dout_q <= buf_dout_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
        end
    end

    assign cmd_ready = ready_q;
    assign buf_oe    = buf_oe_q;
    assign buf_od    = buf_od_q;
    assign buf_dir   = buf_dir_q;
    assign buf_dout  = buf_dout_q;
    assign din_sync  = sync2_q;
    assign done      = done_q;
    assign cmd_err   = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_iobuff_sequencer.sv
// Directed bench for iobuff_sequencer: a 4-channel instance for the main
// sequences and a 3-channel instance for the out-of-range channel case.
module tb_iobuff_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_valid_b;
    logic [1:0] cmd_pin, cmd_pin_b;
    logic       cmd_oe, cmd_od, cmd_dir, cmd_dout;
    logic [3:0] pin_din;

    logic       cmd_ready, done, cmd_err, busy;
    logic [3:0] buf_oe, buf_od, buf_dir, buf_dout, din_sync;

    logic       cmd_ready_b, done_b, cmd_err_b, busy_b;
    logic [2:0] buf_oe_b, buf_od_b, buf_dir_b, buf_dout_b, din_sync_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iobuff_sequencer #(.NPINS(4), .SETTLE(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pin(cmd_pin),
        .cmd_oe(cmd_oe), .cmd_od(cmd_od), .cmd_dir(cmd_dir), .cmd_dout(cmd_dout),
        .buf_oe(buf_oe), .buf_od(buf_od), .buf_dir(buf_dir), .buf_dout(buf_dout),
        .pin_din(pin_din), .din_sync(din_sync),
        .done(done), .cmd_err(cmd_err), .busy(busy)
    );

    iobuff_sequencer #(.NPINS(3), .SETTLE(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_pin(cmd_pin_b),
        .cmd_oe(cmd_oe), .cmd_od(cmd_od), .cmd_dir(cmd_dir), .cmd_dout(cmd_dout),
        .buf_oe(buf_oe_b), .buf_od(buf_od_b), .buf_dir(buf_dir_b), .buf_dout(buf_dout_b),
        .pin_din(pin_din[2:0]), .din_sync(din_sync_b),
        .done(done_b), .cmd_err(cmd_err_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one command at a negedge, let it be taken on the next rising
    // edge, then scramble the fields so only the latched copy can matter.
    task automatic send(input logic [1:0] pin, input logic oe, input logic od,
                        input logic dir, input logic dout);
        cmd_valid = 1'b1;
        cmd_pin   = pin;
        cmd_oe    = oe;
        cmd_od    = od;
        cmd_dir   = dir;
        cmd_dout  = dout;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_pin   = ~pin;
        cmd_oe    = ~oe;
        cmd_od    = ~od;
        cmd_dir   = ~dir;
        cmd_dout  = ~dout;
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_valid_b = 1'b0;
        cmd_pin     = 2'd0;
        cmd_pin_b   = 2'd0;
        cmd_oe      = 1'b0;
        cmd_od      = 1'b0;
        cmd_dir     = 1'b0;
        cmd_dout    = 1'b0;
        pin_din     = 4'd0;

        // Reset state
        #2;
        chk("rst_oe",    32'(buf_oe),   32'h0);
        chk("rst_dir",   32'(buf_dir),  32'h0);
        chk("rst_done",  32'(done),     32'h0);
        chk("rst_busy",  32'(busy),     32'h0);
        chk("rst_sync",  32'(din_sync), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'h1);

        // Slow path without OE_OFF: pin1 oe=1 od=0 dir=1 dout=1
        send(2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("a_busy",   32'(busy),      32'h1);
        chk("a_ready",  32'(cmd_ready), 32'h0);
        chk("a_dir",    32'(buf_dir),   32'h2);
        chk("a_dout",   32'(buf_dout),  32'h2);
        chk("a_oe1",    32'(buf_oe),    32'h0);
        cycles(7);
        chk("a_done8",  32'(done),      32'h0);
        chk("a_oe8",    32'(buf_oe),    32'h0);
        cycles(1);
        chk("a_done9",  32'(done),      32'h1);
        chk("a_err9",   32'(cmd_err),   32'h0);
        chk("a_oe9",    32'(buf_oe),    32'h2);
        cycles(1);
        chk("a_rdy10",  32'(cmd_ready), 32'h1);
        chk("a_done10", 32'(done),      32'h0);
        chk("a_busy10", 32'(busy),      32'h0);

        // Slow path with OE_OFF: pin1 dir 1->0
        send(2'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("b_oe1",  32'(buf_oe),  32'h0);
        chk("b_dir1", 32'(buf_dir), 32'h2);
        for (int k = 2; k <= 8; k++) begin
            cycles(1);
            chk("b_oe_off", 32'(buf_oe),  32'h0);
            chk("b_dir_hold", 32'(buf_dir), 32'h2);
        end
        cycles(1);
        chk("b_dir9",   32'(buf_dir),  32'h0);
        chk("b_oe9",    32'(buf_oe),   32'h0);
        chk("b_dout9",  32'(buf_dout), 32'h2);
        cycles(7);
        chk("b_done16", 32'(done),     32'h0);
        chk("b_oe16",   32'(buf_oe),   32'h0);
        cycles(1);
        chk("b_done17", 32'(done),     32'h1);
        chk("b_oe17",   32'(buf_oe),   32'h2);
        cycles(1);
        chk("b_rdy18",  32'(cmd_ready), 32'h1);

        // Fast path: pin1 dout 1->0 only
        send(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("c_dout", 32'(buf_dout), 32'h0);
        chk("c_done", 32'(done),     32'h1);
        chk("c_err",  32'(cmd_err),  32'h0);
        chk("c_oe1",  32'(buf_oe),   32'h2);
        cycles(1);
        chk("c_done2", 32'(done),      32'h0);
        chk("c_rdy2",  32'(cmd_ready), 32'h1);
        chk("c_oe2",   32'(buf_oe),    32'h2);

        // Out-of-range channel on the 3-channel instance
        cmd_valid_b = 1'b1;
        cmd_pin_b   = 2'd3;
        cmd_oe = 1'b1; cmd_od = 1'b1; cmd_dir = 1'b1; cmd_dout = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_b = 1'b0;
        chk("d_done", 32'(done_b),     32'h1);
        chk("d_err",  32'(cmd_err_b),  32'h1);
        chk("d_oe",   32'(buf_oe_b),   32'h0);
        chk("d_od",   32'(buf_od_b),   32'h0);
        chk("d_dir",  32'(buf_dir_b),  32'h0);
        chk("d_dout", 32'(buf_dout_b), 32'h0);
        cycles(1);
        chk("d_done2", 32'(done_b),      32'h0);
        chk("d_err2",  32'(cmd_err_b),   32'h0);
        chk("d_rdy2",  32'(cmd_ready_b), 32'h1);

        // Input synchronizer latency
        pin_din = 4'b0001;
        cycles(1);
        chk("s_one_edge", 32'(din_sync), 32'h0);
        cycles(1);
        chk("s_two_edge", 32'(din_sync), 32'h1);
        pin_din = 4'b0000;
        cycles(1);
        chk("s_fall1", 32'(din_sync), 32'h1);
        cycles(1);
        chk("s_fall2", 32'(din_sync), 32'h0);

        // Command held during busy: pin2 slow, then pin0 fast accepted after done
        cmd_valid = 1'b1;
        cmd_pin = 2'd2; cmd_oe = 1'b1; cmd_od = 1'b1; cmd_dir = 1'b1; cmd_dout = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_pin = 2'd0; cmd_oe = 1'b0; cmd_od = 1'b0; cmd_dir = 1'b0; cmd_dout = 1'b1;
        chk("e_od1",   32'(buf_od),   32'h4);
        chk("e_dir1",  32'(buf_dir),  32'h4);
        chk("e_dout1", 32'(buf_dout), 32'h4);
        chk("e_oe1",   32'(buf_oe),   32'h2);
        chk("e_busy1", 32'(busy),     32'h1);
        cycles(8);
        chk("e_done9", 32'(done),     32'h1);
        chk("e_oe9",   32'(buf_oe),   32'h6);
        chk("e_dout9", 32'(buf_dout), 32'h4);
        cycles(1);
        chk("e_rdy10",  32'(cmd_ready), 32'h1);
        chk("e_done10", 32'(done),      32'h0);
        cycles(1);
        cmd_valid = 1'b0;
        chk("e_done11", 32'(done),     32'h1);
        chk("e_err11",  32'(cmd_err),  32'h0);
        chk("e_dout11", 32'(buf_dout), 32'h5);
        chk("e_oe11",   32'(buf_oe),   32'h6);
        chk("e_od11",   32'(buf_od),   32'h4);
        cycles(1);
        chk("e_done12", 32'(done), 32'h0);
        chk("e_busy12", 32'(busy), 32'h0);

        // Reset in the middle of a slow-path command
        send(2'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("f_dir1", 32'(buf_dir), 32'hc);
        cycles(4);
        chk("f_busy5", 32'(busy), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("f_oe_rst",   32'(buf_oe),   32'h0);
        chk("f_od_rst",   32'(buf_od),   32'h0);
        chk("f_dir_rst",  32'(buf_dir),  32'h0);
        chk("f_dout_rst", 32'(buf_dout), 32'h0);
        chk("f_busy_rst", 32'(busy),     32'h0);
        chk("f_done_rst", 32'(done),     32'h0);
        @(negedge clk);
        chk("f_done_hold", 32'(done), 32'h0);
        rst_n = 1'b1;
        cycles(1);
        chk("f_rdy_rel",  32'(cmd_ready), 32'h1);
        chk("f_done_rel", 32'(done),      32'h0);
        send(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("f_busy_new", 32'(busy),   32'h1);
        chk("f_od_new",   32'(buf_od), 32'h1);
        cycles(8);
        chk("f_done_new", 32'(done),   32'h1);
        chk("f_oe_new",   32'(buf_oe), 32'h0);
        cycles(1);
        chk("f_rdy_end",  32'(cmd_ready), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iobuff_sequencer.md
IOBUFF_SEQUENCER -- requirements
Module: iobuff_sequencer

Interface
REQ-001 SHALL have parameter NPINS, default 4: number of managed iobuff channels, legal range 1..4.
REQ-002 SHALL have parameter SETTLE, default 8: settle wait in clk cycles, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: a configuration command is presented.
REQ-006 SHALL have port cmd_ready, output, 1 bit: the sequencer can accept a command.
REQ-007 SHALL have port cmd_pin, input, 2 bits: target channel index.
REQ-008 SHALL have ports cmd_oe, cmd_od, cmd_dir, cmd_dout, inputs, 1 bit each: requested output enable, open-drain, buffer direction and data.
REQ-009 SHALL have ports buf_oe, buf_od, buf_dir, buf_dout, outputs, NPINS bits each: per-channel controls to the iobuff instances.
REQ-010 SHALL have port pin_din, input, NPINS bits: raw pin input data.
REQ-011 SHALL have port din_sync, output, NPINS bits: pin_din after a 2-flop synchronizer.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port cmd_err, output, 1 bit: one-cycle pulse, coincident with done, marking a rejected command.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL accept a command on a rising edge where cmd_valid=1 and cmd_ready=1 (edge T); cmd_ready SHALL equal 1 only in IDLE.
REQ-016 SHALL latch cmd_pin, cmd_oe, cmd_od, cmd_dir and cmd_dout at T; later changes on those inputs SHALL have no effect.
REQ-017 SHALL implement the states IDLE, OE_OFF, APPLY and DONE.
REQ-018 Invalid pin (cmd_pin >= NPINS): SHALL go IDLE->DONE; at T+1 done=1 and cmd_err=1; no buf_* output changes.
REQ-019 Fast path (cmd_oe, cmd_od and cmd_dir all equal the current values for the target pin): SHALL go IDLE->DONE, updating buf_dout[pin] at T+1 with done=1.
REQ-020 Slow path with current buf_oe[pin]=1: SHALL go IDLE->OE_OFF; buf_oe[pin]=0 from T+1; SHALL hold OE_OFF for SETTLE cycles.
REQ-021 APPLY: on entry SHALL update buf_od, buf_dir and buf_dout for the pin; SHALL hold APPLY for SETTLE cycles; buf_oe[pin] SHALL remain 0.
REQ-022 Slow path with current buf_oe[pin]=0: SHALL skip OE_OFF, with APPLY entered at T+1.
REQ-023 DONE: SHALL set buf_oe[pin]=cmd_oe and pulse done; SHALL return to IDLE next cycle. With OE_OFF, DONE is at T+2*SETTLE+1; without OE_OFF, at T+SETTLE+1.
REQ-024 SHALL leave channels other than the target pin unchanged at every cycle.
REQ-025 SHALL never drive buf_oe[pin]=1 in any cycle where buf_dir[pin] or buf_od[pin] differs from its final value.
REQ-026 SHALL use an 8-bit settle counter that never wraps; it SHALL load SETTLE-1 on state entry and the state SHALL advance when it reaches 0.
REQ-027 cmd_valid while busy SHALL be ignored (no queueing); the command SHALL be accepted in the first IDLE cycle that still sees cmd_valid=1.
REQ-028 din_sync SHALL run continuously, independent of the FSM.

Reset
REQ-029 rst_n=0 SHALL immediately set: state=IDLE; buf_oe, buf_od, buf_dir and buf_dout all 0; done=0; cmd_err=0; busy=0; counter=0; synchronizer flops=0.
REQ-030 rst_n asserted mid-sequence SHALL abort the sequence with no done pulse; cmd_ready=1 on the first edge after rst_n rises.

Verification
REQ-031 Reset, SETTLE=8, pin 1 command oe=1,od=0,dir=1,dout=1 (current oe=0): APPLY at T+1; buf_dir[1]=1 and buf_dout[1]=1 at T+1; buf_oe[1]=1 and done at T+9; cmd_ready=1 at T+10.
REQ-032 From REQ-031 state, pin 1 command dir=0 (other fields the same): buf_oe[1]=0 over T+1..T+8; buf_dir[1]=0 at T+9; buf_oe[1]=1 and done at T+17.
REQ-033 Pin 1 command changing only dout 1->0: buf_dout[1]=0 and done=1 at T+1; buf_oe[1] stays 1 throughout.
REQ-034 NPINS=3, cmd_pin=3: done=1 and cmd_err=1 at T+1; all buf_* outputs unchanged.
REQ-035 rst_n pulsed low at T+5 of a slow-path command: all buf_* outputs=0 asynchronously; no done pulse; a new command is accepted after release.
REQ-036 Toggle pin_din[0]: din_sync[0] follows exactly 2 edges later; a second cmd_valid held during busy is accepted in the cycle after done.
